// File: rtl/up_axi_initiator_pkg.sv
// up_axi_initiator_pkg
// Shared types and constants for the up_axi_initiator AXI4-Lite master:
// FSM state encoding, AXI response codes, the read data returned on a
// watchdog abort, and the response-to-error mapping.
package up_axi_initiator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

    // AXI4-Lite has no exclusive access, so EXOKAY is reported as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/up_axi_initiator_if.sv
// up_axi_initiator_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) between the initiator and
// a register slave.
//   master modport : drives valids/addresses/data/bready/rready
//   slave modport  : drives readies, bvalid/bresp, rvalid/rdata/rresp
interface up_axi_initiator_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/up_axi_initiator_wdog.sv
// up_axi_initiator_wdog
// Transaction watchdog for up_axi_initiator (built only with
// AXI_INIT_TIMEOUT_EN).
//   up_clk, up_rstn : clock, synchronous active-low reset
//   clear           : command accepted, restart the count
//   count_en        : FSM is waiting on the AXI bus
//   hit             : the count reaches TIMEOUT_CYCLES at this edge
module up_axi_initiator_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic up_clk,
    input  logic up_rstn,
    input  logic clear,
    input  logic count_en,
    output logic hit
);

    localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYCLES);

    logic [15:0] count;

    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    // Flag the edge on which the counter would reach the limit, so the FSM
    // aborts exactly TIMEOUT_CYCLES cycles after acceptance.
    assign hit = count_en && (({1'b0, count} + 17'd1) == LIMIT);

endmodule

// File: rtl/up_axi_initiator.sv
// up_axi_initiator
// Single-outstanding AXI4-Lite master: turns register commands into AXI4-Lite
// writes/reads and returns one response per command.
// Optional feature: define AXI_INIT_TIMEOUT_EN to add a transaction watchdog
// (TIMEOUT_CYCLES); without it the block waits on the bus indefinitely.
// Ports:
//   up_clk, up_rstn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_wr, cmd_addr[13:0]     1 = write; word address
//   cmd_wdata[31:0], cmd_wstrb write data and byte strobes
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata[31:0]            read data (0 for writes)
//   rsp_err, rsp_timeout       non-OKAY response or abort; watchdog abort
//   m_axi                      AXI4-Lite master bus
module up_axi_initiator
    import up_axi_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [2:0]  AXI_PROT       = 3'b000
) (
    input  logic               up_clk,
    input  logic               up_rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic [13:0]        cmd_addr,
    input  logic [31:0]        cmd_wdata,
    input  logic [3:0]         cmd_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               rsp_timeout,
    up_axi_initiator_if.master m_axi
);

    state_t      state;
    logic        accept;
    logic        aw_pending;
    logic        w_pending;
    logic        step_done;
    logic        timeout_hit;
    logic [31:0] cmd_byte_addr;

    assign accept        = cmd_valid && cmd_ready;
    assign cmd_byte_addr = {16'd0, cmd_addr, 2'b00};
    assign aw_pending    = m_axi.awvalid && !m_axi.awready;
    assign w_pending     = m_axi.wvalid && !m_axi.wready;

    assign m_axi.awprot = AXI_PROT;
    assign m_axi.arprot = AXI_PROT;

    // The current bus phase finishes at this edge.
    always_comb begin
        step_done = 1'b0;
        case (state)
            WR_REQ:  step_done = !aw_pending && !w_pending;
            WR_RESP: step_done = m_axi.bvalid;
            RD_REQ:  step_done = m_axi.arready;
            RD_RESP: step_done = m_axi.rvalid;
            default: step_done = 1'b0;
        endcase
    end

`ifdef AXI_INIT_TIMEOUT_EN
    logic busy;
    assign busy = (state == WR_REQ) || (state == WR_RESP) ||
                  (state == RD_REQ) || (state == RD_RESP);

    up_axi_initiator_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .up_clk  (up_clk),
        .up_rstn (up_rstn),
        .clear   (accept),
        .count_en(busy),
        .hit     (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
            m_axi.awaddr  <= '0;
            m_axi.araddr  <= '0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        if (cmd_wr) begin
                            m_axi.awaddr  <= cmd_byte_addr;
                            m_axi.wdata   <= cmd_wdata;
                            m_axi.wstrb   <= cmd_wstrb;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi.araddr  <= cmd_byte_addr;
                            m_axi.arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently, in any order.
                    if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
                    if (step_done) begin
                        m_axi.bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (step_done) begin
                        m_axi.bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_err      <= resp_is_err(m_axi.bresp);
                        rsp_timeout  <= 1'b0;
                        state        <= RSP;
                    end
                end
                RD_REQ: begin
                    if (step_done) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (step_done) begin
                        m_axi.rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= m_axi.rdata;
                        rsp_err      <= resp_is_err(m_axi.rresp);
                        rsp_timeout  <= 1'b0;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Watchdog abort; a handshake completing on the same edge wins.
            if (timeout_hit && !step_done) begin
                m_axi.awvalid <= 1'b0;
                m_axi.wvalid  <= 1'b0;
                m_axi.arvalid <= 1'b0;
                m_axi.bready  <= 1'b0;
                m_axi.rready  <= 1'b0;
                rsp_valid     <= 1'b1;
                rsp_rdata     <= TIMEOUT_RDATA;
                rsp_err       <= 1'b1;
                rsp_timeout   <= 1'b1;
                state         <= RSP;
            end
        end
    end

endmodule

// File: tb/tb_up_axi_initiator.sv
// tb_up_axi_initiator
// Directed bench for up_axi_initiator. The slave side of the AXI bus is
// driven step by step from a single initial block; inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_up_axi_initiator;

    logic        clk = 1'b0;
    logic        up_rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [13:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int checks = 0;
    int errors = 0;

    up_axi_initiator_if m_axi ();

    up_axi_initiator #(
        .TIMEOUT_CYCLES(8),
        .AXI_PROT      (3'b010)
    ) dut (
        .up_clk     (clk),
        .up_rstn    (up_rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .m_axi      (m_axi)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [13:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        up_rstn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        m_axi.bvalid  = 1'b0;
        m_axi.bresp   = 2'b00;
        m_axi.arready = 1'b0;
        m_axi.rvalid  = 1'b0;
        m_axi.rdata   = '0;
        m_axi.rresp   = 2'b00;

        // ---------------- reset state
        step();
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_valids", {27'd0, m_axi.awvalid, m_axi.wvalid, m_axi.arvalid,
                           m_axi.bready, m_axi.rready}, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_fields", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'd0);
        chk("rst_awaddr", m_axi.awaddr, 32'd0);
        chk("rst_araddr", m_axi.araddr, 32'd0);
        chk("rst_wdata", m_axi.wdata, 32'd0);
        chk("rst_wstrb", 32'(m_axi.wstrb), 32'd0);
        up_rstn = 1'b1;
        step();
        chk("rst_cmd_ready_rise", 32'(cmd_ready), 32'd1);
        chk("awprot", 32'(m_axi.awprot), 32'd2);
        chk("arprot", 32'(m_axi.arprot), 32'd2);

        // ---------------- zero-wait write
        m_axi.awready = 1'b1;
        m_axi.wready  = 1'b1;
        issue(1'b1, 14'h0010, 32'h1234_5678, 4'hF);
        chk("w0_cmd_ready_fall", 32'(cmd_ready), 32'd0);
        chk("w0_awvalid", 32'(m_axi.awvalid), 32'd1);
        chk("w0_wvalid", 32'(m_axi.wvalid), 32'd1);
        chk("w0_awaddr", m_axi.awaddr, 32'h0000_0040);
        chk("w0_wdata", m_axi.wdata, 32'h1234_5678);
        chk("w0_wstrb", 32'(m_axi.wstrb), 32'hF);
        step();
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        chk("w0_valids_drop", {30'd0, m_axi.awvalid, m_axi.wvalid}, 32'd0);
        chk("w0_bready", 32'(m_axi.bready), 32'd1);
        chk("w0_no_rsp_yet", 32'(rsp_valid), 32'd0);
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = 2'b00;
        step();
        m_axi.bvalid = 1'b0;
        chk("w0_bready_drop", 32'(m_axi.bready), 32'd0);
        chk("w0_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w0_rsp_err", 32'(rsp_err), 32'd0);
        chk("w0_rsp_rdata", rsp_rdata, 32'd0);
        chk("w0_rsp_timeout", 32'(rsp_timeout), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("w0_rsp_done", 32'(rsp_valid), 32'd0);
        chk("w0_cmd_ready_rise", 32'(cmd_ready), 32'd1);

        // ---------------- read with arready delayed 5 cycles
        issue(1'b0, 14'h0123, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            chk("r1_arvalid_hold", 32'(m_axi.arvalid), 32'd1);
            chk("r1_araddr_stable", m_axi.araddr, 32'h0000_048C);
            step();
        end
        chk("r1_rready_early", 32'(m_axi.rready), 32'd0);
        m_axi.arready = 1'b1;
        step();
        m_axi.arready = 1'b0;
        chk("r1_arvalid_drop", 32'(m_axi.arvalid), 32'd0);
        chk("r1_rready", 32'(m_axi.rready), 32'd1);
        m_axi.rvalid = 1'b1;
        m_axi.rdata  = 32'hCAFE_0001;
        m_axi.rresp  = 2'b00;
        step();
        m_axi.rvalid = 1'b0;
        m_axi.rdata  = 32'h0;
        chk("r1_rready_drop", 32'(m_axi.rready), 32'd0);
        chk("r1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r1_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("r1_rsp_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // ---------------- write with wready two cycles before awready
        issue(1'b1, 14'h3FFF, 32'hA5A5_0F0F, 4'h5);
        chk("w2_awaddr", m_axi.awaddr, 32'h0000_FFFC);
        m_axi.wready = 1'b1;
        step();
        m_axi.wready = 1'b0;
        chk("w2_wvalid_drop", 32'(m_axi.wvalid), 32'd0);
        chk("w2_awvalid_hold", 32'(m_axi.awvalid), 32'd1);
        chk("w2_bready_wait", 32'(m_axi.bready), 32'd0);
        step();
        chk("w2_awvalid_hold2", 32'(m_axi.awvalid), 32'd1);
        chk("w2_bready_wait2", 32'(m_axi.bready), 32'd0);
        m_axi.awready = 1'b1;
        step();
        m_axi.awready = 1'b0;
        chk("w2_awvalid_drop", 32'(m_axi.awvalid), 32'd0);
        chk("w2_bready", 32'(m_axi.bready), 32'd1);
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = 2'b01;
        step();
        m_axi.bvalid = 1'b0;
        m_axi.bresp  = 2'b00;
        chk("w2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w2_exokay_err", 32'(rsp_err), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // ---------------- read with SLVERR, response held under backpressure
        m_axi.arready = 1'b1;
        issue(1'b0, 14'h0002, 32'h0, 4'h0);
        step();
        m_axi.arready = 1'b0;
        m_axi.rvalid  = 1'b1;
        m_axi.rdata   = 32'h5555_AAAA;
        m_axi.rresp   = 2'b10;
        step();
        m_axi.rvalid = 1'b0;
        m_axi.rresp  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            chk("r3_rsp_valid_hold", 32'(rsp_valid), 32'd1);
            chk("r3_rsp_rdata", rsp_rdata, 32'h5555_AAAA);
            chk("r3_err_to", {30'd0, rsp_err, rsp_timeout}, 32'd2);
            chk("r3_cmd_ready_low", 32'(cmd_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("r3_rsp_done", 32'(rsp_valid), 32'd0);
        chk("r3_cmd_ready", 32'(cmd_ready), 32'd1);

        // ---------------- slave never answers arready
        issue(1'b0, 14'h0007, 32'h0, 4'h0);
`ifdef AXI_INIT_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step();
        chk("t4_arvalid_before_limit", 32'(m_axi.arvalid), 32'd1);
        chk("t4_no_rsp_before_limit", 32'(rsp_valid), 32'd0);
        step();
        chk("t4_arvalid_abort", 32'(m_axi.arvalid), 32'd0);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4_rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("t4_rsp_err", 32'(rsp_err), 32'd1);
        chk("t4_rsp_rdata", rsp_rdata, 32'hDEAD_DEAD);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        m_axi.arready = 1'b1;
        issue(1'b0, 14'h0001, 32'h0, 4'h0);
        chk("t4_next_accepted", 32'(m_axi.arvalid), 32'd1);
        chk("t4_next_araddr", m_axi.araddr, 32'h0000_0004);
        step();
        m_axi.arready = 1'b0;
        m_axi.rvalid  = 1'b1;
        m_axi.rdata   = 32'h0000_0001;
        step();
        m_axi.rvalid = 1'b0;
        chk("t4_next_rdata", rsp_rdata, 32'h0000_0001);
        chk("t4_next_timeout_clear", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`else
        for (int i = 0; i < 20; i++) step();
        chk("t4_arvalid_waits", 32'(m_axi.arvalid), 32'd1);
        chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
        m_axi.arready = 1'b1;
        step();
        m_axi.arready = 1'b0;
        m_axi.rvalid  = 1'b1;
        m_axi.rdata   = 32'h0BAD_F00D;
        step();
        m_axi.rvalid = 1'b0;
        chk("t4_late_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("t4_late_timeout", 32'(rsp_timeout), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`endif

        // ---------------- reset during WR_RESP
        m_axi.awready = 1'b1;
        m_axi.wready  = 1'b1;
        issue(1'b1, 14'h0020, 32'hFFFF_0000, 4'h3);
        step();
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        chk("r5_in_wr_resp", 32'(m_axi.bready), 32'd1);
        up_rstn = 1'b0;
        step();
        up_rstn = 1'b1;
        chk("r5_valids_cleared", {27'd0, m_axi.awvalid, m_axi.wvalid, m_axi.arvalid,
                                  m_axi.bready, m_axi.rready}, 32'd0);
        chk("r5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("r5_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("r5_awaddr", m_axi.awaddr, 32'd0);
        m_axi.bvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r5_no_response", 32'(rsp_valid), 32'd0);
            chk("r5_no_bready", 32'(m_axi.bready), 32'd0);
        end
        m_axi.bvalid = 1'b0;
        chk("r5_cmd_ready_back", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
